majority_vote_session: RTL

Parametrised N-voter ballot controller: the next generation of the team's switch-driven three-input voter. It debounces N voter switches, runs a timed voting window started by a push-button, freezes the ballot at window close, and tallies it. It then drives an agreement LED under one of four selectable decision rules. It sits between the board switch/button inputs and the LED / seven-segment display logic.

---
 rtl/majority_vote_session.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/majority_vote_session.sv
// N-voter ballot controller: synchronises and debounces voter switches, runs a
// timed voting window opened by a push-button, freezes the ballot and tallies it.
module majority_vote_session #(
   parameter int NUM_VOTERS      = 7,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int WINDOW_CYCLES   = 50000000,
   parameter int THRESHOLD       = 4,
   localparam int CW             = $clog2(NUM_VOTERS + 1),
   localparam int TW             = $clog2(WINDOW_CYCLES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_VOTERS-1:0] sw,
   input  logic                  start,
   input  logic                  clear,
   input  logic [1:0]            mode,
   output logic                  busy,
   output logic                  result_valid,
   output logic                  agreement,
   output logic [CW-1:0]         yes_count,
   output logic [TW-1:0]         time_left
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] OPEN   = 2'd1;
   localparam logic [1:0] TALLY  = 2'd2;
   localparam logic [1:0] RESULT = 2'd3;

   logic [1:0]            state;
   logic [1:0]            rst_sync;
   logic [NUM_VOTERS-1:0] sw_s1, sw_s2, deb, ballot;
   logic [DW-1:0]         db_cnt [NUM_VOTERS];
   logic                  start_s1, start_s2, start_d, start_p;
   logic                  clear_s1, clear_s2, clear_d, clear_p;
   logic [1:0]            mode_r;
   logic [CW-1:0]         pop;
   logic [31:0]           c32;
   logic                  agree_next;
   logic                  rst_ok;

   assign rst_ok = rst_sync[1];

   // Reset assertion is immediate; release reaches the FSM two edges later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1    <= '0;
         sw_s2    <= '0;
         start_s1 <= 1'b0;
         start_s2 <= 1'b0;
         start_d  <= 1'b0;
         start_p  <= 1'b0;
         clear_s1 <= 1'b0;
         clear_s2 <= 1'b0;
         clear_d  <= 1'b0;
         clear_p  <= 1'b0;
      end else begin
         sw_s1    <= sw;
         sw_s2    <= sw_s1;
         start_s1 <= start;
         start_s2 <= start_s1;
         start_d  <= start_s2;
         start_p  <= start_s2 & ~start_d;
         clear_s1 <= clear;
         clear_s2 <= clear_s1;
         clear_d  <= clear_s2;
         clear_p  <= clear_s2 & ~clear_d;
      end
   end

   // A channel's counter runs only while its input disagrees with the
   // debounced value; any agreeing sample restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb <= '0;
         for (int i = 0; i < NUM_VOTERS; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_VOTERS; i++) begin
            if (sw_s2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb[i]    <= sw_s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_VOTERS; i++) pop = pop + CW'(ballot[i]);
   end

   assign c32 = 32'(pop);

   always_comb begin
      agree_next = 1'b0;
      case (mode_r)
         2'b00:   agree_next = (32'd2 * c32) > 32'(NUM_VOTERS);
         2'b01:   agree_next = (32'd3 * c32) >= (32'd2 * 32'(NUM_VOTERS));
         2'b10:   agree_next = c32 == 32'(NUM_VOTERS);
         default: agree_next = c32 >= 32'(THRESHOLD);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         agreement    <= 1'b0;
         yes_count    <= '0;
         time_left    <= '0;
         ballot       <= '0;
         mode_r       <= 2'b00;
      end else if (rst_ok) begin
         case (state)
            IDLE: begin
               if (start_p) begin
                  state     <= OPEN;
                  busy      <= 1'b1;
                  time_left <= TW'(WINDOW_CYCLES - 1);
               end
            end
            OPEN: begin
               if (clear_p) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  time_left <= '0;
               end else if (time_left == '0) begin
                  ballot <= deb;
                  mode_r <= mode;
                  state  <= TALLY;
               end else begin
                  time_left <= time_left - 1'b1;
               end
            end
            TALLY: begin
               yes_count    <= pop;
               agreement    <= agree_next;
               busy         <= 1'b0;
               result_valid <= 1'b1;
               state        <= RESULT;
            end
            default: begin
               if (clear_p) begin
                  state        <= IDLE;
                  result_valid <= 1'b0;
                  agreement    <= 1'b0;
                  yes_count    <= '0;
               end
            end
         endcase
      end
   end

endmodule
